// File: rtl/axi_stream_length_header_insert_if.sv
// AXI-Stream handshake bundle shared by the framer's input and output sides.
// Master drives data/valid/last; slave returns ready.
interface axi_stream_length_header_insert_if #(
  parameter int DSIZE = 32
);
  logic [DSIZE-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi_stream_length_header_insert.sv
// Store-and-forward framer: buffers each packet, then emits a length header beat
// followed by the payload. Packets longer than DEPTH beats are split and flagged.
module axi_stream_length_header_insert #(
  parameter int DSIZE     = 32,
  parameter int DEPTH     = 1024,
  parameter int PKT_DEPTH = 16
) (
  input  logic aclk,
  input  logic aresetn,
  axi_stream_length_header_insert_if.slave  s_axis,
  axi_stream_length_header_insert_if.master m_axis,
  output logic oversize_err
);

  localparam int LSIZE = $clog2(DEPTH) + 1;
  localparam int DAW   = $clog2(DEPTH);
  localparam int LAW   = $clog2(PKT_DEPTH);
  localparam logic [LSIZE-1:0] CNT_MAX = LSIZE'(DEPTH - 1);
  localparam logic [LSIZE-1:0] CNT_ONE = LSIZE'(1);

  typedef enum logic {HDR, PAY} state_t;

  // Payload and length storage
  logic [DSIZE-1:0] data_mem [DEPTH];
  logic [LSIZE-1:0] len_mem  [PKT_DEPTH];
  logic [DAW:0]     d_wptr, d_rptr;
  logic [LAW:0]     l_wptr, l_rptr;

  logic             data_full;
  logic             len_full;
  logic             len_empty;
  logic [LSIZE-1:0] len_head;

  // Input side
  logic             in_en;
  logic [LSIZE-1:0] w_cnt;
  logic             s_hs;
  logic             force_split;
  logic             pkt_end;

  // Output side
  state_t           state;
  logic [LSIZE-1:0] r_len;
  logic [LSIZE-1:0] r_cnt;
  logic             m_hs;
  logic             pay_last;
  logic             d_pop;
  logic             l_pop;

  // Full when the wrap bits differ and the addresses match; empty when identical.
  assign data_full = (d_wptr[DAW] != d_rptr[DAW]) && (d_wptr[DAW-1:0] == d_rptr[DAW-1:0]);
  assign len_full  = (l_wptr[LAW] != l_rptr[LAW]) && (l_wptr[LAW-1:0] == l_rptr[LAW-1:0]);
  assign len_empty = (l_wptr == l_rptr);
  assign len_head  = len_mem[l_rptr[LAW-1:0]];

  // in_en keeps ready low while reset is asserted and for the first cycle after.
  assign s_axis.tready = in_en && !data_full && !len_full;
  assign s_hs          = s_axis.tvalid && s_axis.tready;
  assign force_split   = (w_cnt == CNT_MAX);
  assign pkt_end       = s_hs && (s_axis.tlast || force_split);

  assign m_hs     = m_axis.tvalid && m_axis.tready;
  assign pay_last = (state == PAY) && (r_cnt == (r_len - CNT_ONE));
  assign d_pop    = m_hs && (state == PAY);
  assign l_pop    = m_hs && pay_last;

  // NOTE: storage arrays have no reset; the pointers alone define what is valid,
  // so clearing the pointers on reset discards every buffered beat.
  always_ff @(posedge aclk) begin
    if (s_hs) begin
      data_mem[d_wptr[DAW-1:0]] <= s_axis.tdata;
    end
    if (pkt_end) begin
      len_mem[l_wptr[LAW-1:0]] <= w_cnt + CNT_ONE;
    end
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_en        <= 1'b0;
      d_wptr       <= '0;
      d_rptr       <= '0;
      l_wptr       <= '0;
      l_rptr       <= '0;
      w_cnt        <= '0;
      oversize_err <= 1'b0;
    end else begin
      in_en        <= 1'b1;
      oversize_err <= s_hs && force_split && !s_axis.tlast;
      if (s_hs) begin
        d_wptr <= d_wptr + 1'b1;
      end
      if (d_pop) begin
        d_rptr <= d_rptr + 1'b1;
      end
      if (pkt_end) begin
        l_wptr <= l_wptr + 1'b1;
        w_cnt  <= '0;
      end else if (s_hs) begin
        w_cnt  <= w_cnt + CNT_ONE;
      end
      if (l_pop) begin
        l_rptr <= l_rptr + 1'b1;
      end
    end
  end

  // Header/payload sequencer; the length stays at the queue head until the
  // final payload beat leaves so the header can be presented with zero bubbles.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= HDR;
      r_len <= '0;
      r_cnt <= '0;
    end else begin
      case (state)
        HDR: begin
          if (m_hs) begin
            r_len <= len_head;
            r_cnt <= '0;
            state <= PAY;
          end
        end
        PAY: begin
          if (m_hs) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (pay_last) begin
              state <= HDR;
            end
          end
        end
        default: state <= HDR;
      endcase
    end
  end

  // NOTE: outputs get defaults before the case so no path leaves them unassigned
  // (which would otherwise infer latches).
  always_comb begin
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = '0;
    m_axis.tlast  = 1'b0;
    case (state)
      HDR: begin
        if (!len_empty) begin
          m_axis.tvalid = 1'b1;
          m_axis.tdata  = DSIZE'(len_head);
        end
      end
      PAY: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = data_mem[d_rptr[DAW-1:0]];
        m_axis.tlast  = pay_last;
      end
      default: ;
    endcase
  end

endmodule
